// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared word width, arbitration modes and controller states
package mem_port_arbiter_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection, fixed priority or round-robin after last
module mem_arb_pick #(
  parameter int NCH = 2,
  parameter int IW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  input  logic           rr,
  output logic [IW-1:0]  g,
  output logic           any
);
  logic [IW-1:0] idx;
  // Scan from the farthest candidate to the nearest so the nearest requester is the final winner
  always_comb begin
    g = '0;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = IW'(rr ? (int'(last) + 1 + i) % NCH : i);
      if (req[idx]) g = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between NCH requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = WORD_WIDTH,
  parameter int NCH = 2,
  parameter int MEM_LAT = 1,
  parameter int RR = RR_FIXED,
  parameter int IW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] we,
  input  logic [NCH*W-1:0] addr,
  input  logic [NCH*W-1:0] wdata,
  output logic [NCH-1:0] ack,
  output logic [W-1:0]   rdata,
  output logic [IW-1:0]  gnt_id,
  output logic           busy,
  output logic           mem_en,
  output logic           mem_we,
  output logic [W-1:0]   mem_addr,
  output logic [W-1:0]   mem_wdata,
  input  logic [W-1:0]   mem_rdata
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  arb_state_e state, state_d;
  logic [IW-1:0] last, g;
  logic any, we_q, sel_we;
  logic [W-1:0] addr_q, wdata_q, sel_addr, sel_wdata;
  logic [CW-1:0] cnt;
  mem_arb_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req (req),
    .last(last),
    .rr  (RR == RR_ROUND),
    .g   (g),
    .any (any)
  );
  // Route the winning channel's operands to the latch inputs
  always_comb begin
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g == IW'(i)) begin
        sel_we = we[i];
        sel_addr = addr[i*W +: W];
        sel_wdata = wdata[i*W +: W];
      end
    end
  end
  // Controller state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_d;
  end
  // Next state: grant from IDLE, writes skip WAIT, reads wait out the memory latency
  always_comb begin
    state_d = state == IDLE   ? (any ? ACCESS : IDLE)
            : state == ACCESS ? (we_q ? DONE : WAIT)
            : state == WAIT   ? (cnt == '0 ? DONE : WAIT)
            : IDLE;
  end
  // Latch the winner's operands on grant, count read latency, capture read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= IW'(NCH - 1);
      gnt_id <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      rdata <= '0;
    end else begin
      if (state == IDLE && any) begin
        last <= g;
        gnt_id <= g;
        we_q <= sel_we;
        addr_q <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == ACCESS) cnt <= CW'(MEM_LAT - 1);
      if (state == WAIT) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) rdata <= mem_rdata;
      end
    end
  end
  assign busy = state != IDLE;
  assign mem_en = state == ACCESS;
  assign mem_we = mem_en & we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign ack = state == DONE ? NCH'(1) << gnt_id : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of fixed-priority and round-robin arbiter instances
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  logic [1:0] a_req, a_we, a_ack;
  logic [2*W-1:0] a_addr, a_wdata;
  logic [W-1:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic a_gnt, a_busy, a_men, a_mwe;
  mem_port_arbiter #(.W(W), .NCH(2), .MEM_LAT(2), .RR(RR_FIXED)) dut_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .ack(a_ack), .rdata(a_rdata), .gnt_id(a_gnt), .busy(a_busy), .mem_en(a_men),
    .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
  );

  logic [3:0] b_req, b_we, b_ack;
  logic [4*W-1:0] b_addr, b_wdata;
  logic [W-1:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic [1:0] b_gnt;
  logic b_busy, b_men, b_mwe;
  mem_port_arbiter #(.W(W), .NCH(4), .MEM_LAT(3), .RR(RR_ROUND)) dut_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ack(b_ack), .rdata(b_rdata), .gnt_id(b_gnt), .busy(b_busy), .mem_en(b_men),
    .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
  );

  logic [W-1:0] mem_a [256];
  logic [W-1:0] pa [2];
  always @(posedge clk) begin
    if (!rst) mem_a[8'h40] <= 32'hDEADBEEF;
    else if (a_men && a_mwe) mem_a[a_maddr[7:0]] <= a_mwdata;
    if (a_men) pa[0] <= mem_a[a_maddr[7:0]];
    pa[1] <= pa[0];
  end
  assign a_mrdata = pa[1];

  logic [W-1:0] mem_b [256];
  logic [W-1:0] pb [3];
  always @(posedge clk) begin
    if (!rst) begin
      mem_b[8'h10] <= 32'hA0;
      mem_b[8'h11] <= 32'hA1;
      mem_b[8'h12] <= 32'hA2;
      mem_b[8'h13] <= 32'hA3;
    end else if (b_men && b_mwe) mem_b[b_maddr[7:0]] <= b_mwdata;
    if (b_men) pb[0] <= mem_b[b_maddr[7:0]];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b_mrdata = pb[2];

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ack, a_rdata, a_gnt, a_busy, a_men, a_mwe, a_maddr, a_mwdata} !== '0) begin
      errors++;
      $display("FAIL reset_a: ack=%b rdata=%h gnt=%b busy=%b en=%b we=%b addr=%h wdata=%h expected all zero", a_ack, a_rdata, a_gnt, a_busy, a_men, a_mwe, a_maddr, a_mwdata);
    end
    checks++;
    if ({b_ack, b_rdata, b_gnt, b_busy, b_men, b_mwe, b_maddr, b_mwdata} !== '0) begin
      errors++;
      $display("FAIL reset_b: ack=%b rdata=%h gnt=%b busy=%b en=%b we=%b addr=%h wdata=%h expected all zero", b_ack, b_rdata, b_gnt, b_busy, b_men, b_mwe, b_maddr, b_mwdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_busy, b_busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: busy a/b=%b expected 00", {a_busy, b_busy});
    end
  endtask

  task automatic test_single_read;
    @(negedge clk);
    a_req = 2'b10;
    a_we = 2'b00;
    a_addr[W +: W] = 32'h40;
    @(negedge clk);
    checks++;
    if ({a_men, a_mwe, a_busy, a_gnt} !== 4'b1011 || a_maddr !== 32'h40) begin
      errors++;
      $display("FAIL read_access: en/we/busy/gnt=%b addr=%h expected 1011 addr 00000040", {a_men, a_mwe, a_busy, a_gnt}, a_maddr);
    end
    a_req = 2'b00;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_ack !== (c == 4 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL read_ack_cycle%0d: got %b expected %b", c, a_ack, (c == 4 ? 2'b10 : 2'b00));
      end
      if (c == 4) begin
        checks++;
        if (a_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL read_rdata: got %h expected deadbeef", a_rdata);
        end
      end
    end
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL read_idle_after: busy=%b expected 0", a_busy);
    end
  endtask

  task automatic test_single_write;
    @(negedge clk);
    a_req = 2'b10;
    a_we = 2'b10;
    a_addr[W +: W] = 32'h80;
    a_wdata[W +: W] = 32'h1234;
    @(negedge clk);
    checks++;
    if ({a_men, a_mwe} !== 2'b11 || a_maddr !== 32'h80 || a_mwdata !== 32'h1234) begin
      errors++;
      $display("FAIL write_access: en/we=%b addr=%h wdata=%h expected 11 00000080 00001234", {a_men, a_mwe}, a_maddr, a_mwdata);
    end
    a_req = 2'b00;
    a_we = 2'b00;
    @(negedge clk);
    checks++;
    if (a_ack !== 2'b10 || a_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_ack: ack=%b rdata=%h expected 10 deadbeef", a_ack, a_rdata);
    end
    @(negedge clk);
    checks++;
    if (a_ack !== 2'b00 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: ack=%b busy=%b expected 00 0", a_ack, a_busy);
    end
    a_req = 2'b01;
    a_addr[0 +: W] = 32'h80;
    @(negedge clk);
    checks++;
    if (a_men !== 1'b1 || a_gnt !== 1'b0 || a_maddr !== 32'h80) begin
      errors++;
      $display("FAIL readback_access: en=%b gnt=%b addr=%h expected 1 0 00000080", a_men, a_gnt, a_maddr);
    end
    a_req = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_ack !== (c == 4 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL readback_ack_cycle%0d: got %b expected %b", c, a_ack, (c == 4 ? 2'b01 : 2'b00));
      end
    end
    checks++;
    if (a_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL readback_rdata: got %h expected 00001234", a_rdata);
    end
  endtask

  task automatic test_fixed_tie;
    int n0 = 0;
    int n1 = 0;
    @(negedge clk);
    a_req = 2'b11;
    a_we = 2'b00;
    a_addr = {32'h80, 32'h40};
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (a_men) begin
        checks++;
        if (a_gnt !== 1'b0) begin
          errors++;
          $display("FAIL tie_grant_cycle%0d: got %b expected 0", c, a_gnt);
        end
      end
      if (a_ack[0]) begin
        n0++;
        checks++;
        if (a_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL tie_rdata_cycle%0d: got %h expected deadbeef", c, a_rdata);
        end
      end
      if (a_ack[1]) n1++;
    end
    a_req = 2'b00;
    checks++;
    if (n0 !== 4 || n1 !== 0) begin
      errors++;
      $display("FAIL tie_ack_counts: ch0=%0d ch1=%0d expected 4 0", n0, n1);
    end
  endtask

  task automatic test_stability;
    @(negedge clk);
    a_req = 2'b01;
    a_we = 2'b00;
    a_addr[0 +: W] = 32'h40;
    @(negedge clk);
    a_addr[0 +: W] = 32'h80;
    a_req = 2'b00;
    checks++;
    if (a_maddr !== 32'h40 || a_men !== 1'b1) begin
      errors++;
      $display("FAIL stab_access: addr=%h en=%b expected 00000040 1", a_maddr, a_men);
    end
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_ack !== (c == 4 ? 2'b01 : 2'b00) || a_maddr !== 32'h40) begin
        errors++;
        $display("FAIL stab_cycle%0d: ack=%b addr=%h expected %b 00000040", c, a_ack, a_maddr, (c == 4 ? 2'b01 : 2'b00));
      end
    end
    checks++;
    if (a_rdata !== 32'hDEADBEEF || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL stab_rdata: rdata=%h busy=%b expected deadbeef 0", a_rdata, a_busy);
    end
  endtask

  task automatic test_round_robin;
    int k = 0;
    int n = 0;
    logic [3:0] e;
    @(negedge clk);
    b_req = 4'hF;
    b_we = 4'h0;
    b_addr = {32'h13, 32'h12, 32'h11, 32'h10};
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      if (b_men) begin
        checks++;
        if (b_gnt !== 2'(n % 4)) begin
          errors++;
          $display("FAIL rr_grant%0d: got %0d expected %0d", n, b_gnt, n % 4);
        end
        n++;
      end
      if (b_ack !== 4'h0) begin
        e = 4'b0001 << (k % 4);
        checks++;
        if (b_ack !== e || b_rdata !== 32'hA0 + 32'(k % 4)) begin
          errors++;
          $display("FAIL rr_ack%0d: ack=%b rdata=%h expected %b %h", k, b_ack, b_rdata, e, 32'hA0 + 32'(k % 4));
        end
        k++;
      end
    end
    b_req = 4'h0;
    checks++;
    if (n !== 5 || k !== 5) begin
      errors++;
      $display("FAIL rr_counts: grants=%0d acks=%0d expected 5 5", n, k);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    b_req = 4'b0100;
    b_addr[2*W +: W] = 32'h12;
    @(negedge clk);
    b_req = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (b_busy !== 1'b1 || b_gnt !== 2'd2) begin
      errors++;
      $display("FAIL midrst_pre: busy=%b gnt=%0d expected 1 2", b_busy, b_gnt);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_ack, b_rdata, b_gnt, b_busy, b_men, b_mwe, b_maddr, b_mwdata} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ack=%b rdata=%h gnt=%0d busy=%b en=%b we=%b addr=%h wdata=%h expected all zero", b_ack, b_rdata, b_gnt, b_busy, b_men, b_mwe, b_maddr, b_mwdata);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (b_ack !== 4'h0 || b_busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_idle%0d: ack=%b busy=%b expected 0000 0", c, b_ack, b_busy);
      end
    end
    b_req = 4'hF;
    @(negedge clk);
    b_req = 4'h0;
    checks++;
    if (b_men !== 1'b1 || b_gnt !== 2'd0) begin
      errors++;
      $display("FAIL midrst_first_grant: en=%b gnt=%0d expected 1 0", b_men, b_gnt);
    end
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (b_ack !== (c == 5 ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL midrst_ack_cycle%0d: got %b expected %b", c, b_ack, (c == 5 ? 4'b0001 : 4'b0000));
      end
    end
  endtask

  initial begin
    a_req = '0;
    a_we = '0;
    a_addr = '0;
    a_wdata = '0;
    b_req = '0;
    b_we = '0;
    b_addr = '0;
    b_wdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_fixed_tie();
    test_stability();
    test_round_robin();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-channel arbiter that shares one single-port synchronous memory between CPU requesters: instruction fetch, load/store, and later DMA or debug. It replaces the hard-wired fetch-over-load address mux and adds several things that mux lacked: per-channel request/acknowledge handshakes, fixed or round-robin priority, and a configurable memory read latency. It sits between `cpu` and `dbg_mem` in the multicycle top level.

## Interface
- `W`, `WORD_WIDTH`: data and address width.
- `NCH`, 2: number of requester channels; must be 2 or more. Channel 0 is fetch.
- `MEM_LAT`, 1: memory read latency in cycles; must be 1 or more.
- `RR`, 0: arbitration mode. 0 is fixed priority (lowest index wins); 1 is round-robin.
- `IW`, `$clog2(NCH)`: grant index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NCH  per-channel request, held until `ack`.
- `we`  in  NCH  per-channel write enable; 1 means store.
- `addr`  in  NCH*W  flattened addresses; channel i occupies bits [i*W +: W].
- `wdata`  in  NCH*W  flattened write data.
- `ack`  out  NCH  one-cycle completion pulse per channel.
- `rdata`  out  W  read data; valid when `ack[i]` is high for a read.
- `gnt_id`  out  IW  index of the granted channel.
- `busy`  out  1  a transaction is in progress.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  out  W  memory address and write data.
- `mem_rdata`  in  W  memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation
The controller is a state machine with four states: IDLE, ACCESS, WAIT, DONE.
- **IDLE**
  - If any `req` bit is set, pick the winner `g`.
  - Latch `we[g]`, `addr[g]` and `wdata[g]`, set `gnt_id=g`, then go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS** (1 cycle)
  - Drive `mem_en=1`, `mem_we` and `mem_addr`/`mem_wdata` from the latched registers.
  - A write goes to DONE. A read loads a counter with `MEM_LAT-1` and goes to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata` into `rdata` and go to DONE.
- **DONE** (1 cycle)
  - Assert `ack[gnt_id]`, then go to IDLE.
- **Fixed priority**: the lowest set `req` index wins. Fetch therefore wins ties, matching the old behaviour.
- **Round-robin**
  - A pointer `last` holds the most recent grant.
  - Search starts at `last+1` modulo NCH and wraps.
  - `last` updates only on a grant. Its reset value is NCH-1, so channel 0 wins first.
- **Input stability**: channel inputs are sampled only in the IDLE grant cycle. Later changes are ignored.
- **Dropped request**: if `req` drops after the grant, the transaction still completes and `ack` still pulses.
- **Held request**: if `req[i]` is still high in the IDLE cycle after `ack`, it is treated as a new request.
- **Write/read interaction**: `rdata` keeps its last captured value on writes and when idle.
- **Mid-transaction reset**
  - All state returns to IDLE and no `ack` is issued.
  - A write already strobed may have reached memory. An in-flight read is discarded.
- **Reset values**: `ack=0`, `rdata=0`, `gnt_id=0`, `busy=0`, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, state IDLE, `last=NCH-1`.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from `req` to `mem_*`.
- Take cycle 0 as the IDLE cycle where `req` is sampled:
  - ACCESS is cycle 1.
  - A read gives `ack` at cycle `MEM_LAT+2`.
  - A write gives `ack` at cycle 2.
- `busy` is high from ACCESS through DONE inclusive.
- Back-to-back grants are separated by one IDLE cycle.
- Read throughput is one access per `MEM_LAT+3` cycles; write throughput is one per 3 cycles.
- The memory writes on `clk` edges while `mem_en & mem_we`. `dbg_mem` keeps its negedge write clock via the top-level inversion; the arbiter makes no timing change to it.

## Structure
- State encodings and `RR` mode constants go in the shared defines file next to `WORD_WIDTH`.
- Sub-module `mem_arb_pick` is purely combinational winner selection.
  - Inputs: `req`, `last`, `RR`.
  - Outputs: `g` and `any`.
  - It is reusable by a future bus arbiter.
- The top level instantiates one `mem_port_arbiter`. `cpu` fetch connects to channel 0 and load/store to channel 1.

## Test plan
- **Reset**: `rst=0` mid-WAIT with `MEM_LAT=3` → all outputs 0 next cycle, no `ack`, IDLE after release.
- **Single read**: `MEM_LAT=2`, ch1 reads addr 0x40 containing 0xDEADBEEF → `mem_en` at cycle 1, `ack[1]` at cycle 4, `rdata=0xDEADBEEF`.
- **Single write**: ch1 writes 0x1234 to 0x80 → `mem_we=1` at cycle 1, `ack[1]` at cycle 2, then a ch0 read of 0x80 returns 0x1234.
- **Fixed-priority tie**: `req=2'b11` held continuously with `RR=0` → ch0 granted every time, ch1 starved.
- **Round-robin**: `RR=1`, `NCH=4`, all requests held → grant order 0,1,2,3,0 with exactly one `ack` per transaction.
- **Stability**: change `addr[0]` and drop `req[0]` right after the grant → memory sees the original address and `ack[0]` still pulses.
